counter_stream_checker: RTL

Downstream monitor for the free-running modulo counter, which counts 0..MAX and wraps, advancing by one each clock. It samples the counter output every cycle, locks onto the count sequence, and flags any skipped, repeated or out-of-range value. It also counts wrap-arounds for display and debug logic further down the lab design.

---
 rtl/counter_stream_checker_pkg.sv | 21 ++
 rtl/counter_stream_checker_if.sv | 39 +++
 rtl/counter_stream_checker_sat_counter.sv | 32 +++
 rtl/counter_stream_checker.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/counter_stream_checker_pkg.sv
// ---------------------------------------------------------------------------
// counter_stream_checker_pkg
// Shared lab constants for the free-running modulo counter and its checker.
// Holding WIDTH/MAX here keeps the counter and the checker from disagreeing
// about the count range. Also holds the checker state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package counter_stream_checker_pkg;

  // Observed counter geometry: counts 0..CNT_MAX, then wraps to 0
  localparam int CNT_WIDTH = 4;
  localparam int CNT_MAX   = 7;

  // Checker state encoding; 2'd3 is unreachable and decodes as IDLE
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

endpackage

// File: rtl/counter_stream_checker_if.sv
// ---------------------------------------------------------------------------
// counter_stream_checker_if
// Bundles the observed counter stream, the control inputs and the checker
// status outputs.
//   master : drives en, clr, cnt_in; observes the status outputs
//   slave  : the checker side (receives en, clr, cnt_in; drives status)
// Signals:
//   en, clr, cnt_in[WIDTH]                       -> checker
//   locked, err_pulse, err_sticky, wrap_pulse,
//   wrap_cnt[WRAP_W], last_bad[WIDTH]            <- checker
// ---------------------------------------------------------------------------
interface counter_stream_checker_if
  import counter_stream_checker_pkg::*;
#(
  parameter int WIDTH  = CNT_WIDTH,
  parameter int WRAP_W = 8
);

  logic              en;
  logic              clr;
  logic [WIDTH-1:0]  cnt_in;
  logic              locked;
  logic              err_pulse;
  logic              err_sticky;
  logic              wrap_pulse;
  logic [WRAP_W-1:0] wrap_cnt;
  logic [WIDTH-1:0]  last_bad;

  modport master (
    output en, clr, cnt_in,
    input  locked, err_pulse, err_sticky, wrap_pulse, wrap_cnt, last_bad
  );

  modport slave (
    input  en, clr, cnt_in,
    output locked, err_pulse, err_sticky, wrap_pulse, wrap_cnt, last_bad
  );

endinterface

// File: rtl/counter_stream_checker_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating event counter used for the wrap count.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   inc    : count one event this cycle (stops at all-ones)
//   clr    : synchronous clear; an inc in the same cycle still counts,
//            so clr+inc leaves the counter at 1
//   count  : current count
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              clr,
  output logic [WRAP_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? WRAP_W'(1) : '0;
    end else if (inc && (count != '1)) begin
      count <= count + WRAP_W'(1);
    end
  end

endmodule

// File: rtl/counter_stream_checker.sv
// ---------------------------------------------------------------------------
// counter_stream_checker
// Downstream monitor for the free-running modulo counter. Samples cnt_in
// every cycle, locks after SYNC_LEN consecutive correct transitions, then
// flags any skipped, repeated or out-of-range value and counts wraps.
// All outputs are registered (one cycle after the sampling edge).
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of counter_stream_checker_if
//            (en, clr, cnt_in in; locked, err_pulse, err_sticky,
//             wrap_pulse, wrap_cnt, last_bad out)
// ---------------------------------------------------------------------------
module counter_stream_checker
  import counter_stream_checker_pkg::*;
#(
  parameter int WIDTH    = CNT_WIDTH,
  parameter int MAX      = CNT_MAX,
  parameter int SYNC_LEN = 2,
  parameter int WRAP_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  counter_stream_checker_if.slave bus
);

  localparam int GR_W = $clog2(SYNC_LEN + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             prev_valid_q, prev_valid_d;
  logic [GR_W-1:0]  good_run_q, good_run_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic             wrap_pulse_q, wrap_pulse_d;
  logic             err_sticky_q, err_sticky_d;
  logic [WIDTH-1:0] last_bad_q, last_bad_d;
  logic             err_flag;

  logic [WIDTH-1:0] exp_val;
  logic [GR_W-1:0]  good_run_inc;
  logic             in_range;
  logic             good;
  logic             is_wrap;

  // Transition classification against the previous sample. The range check
  // matters when prev itself was out of range (e.g. prev=8 predicts 9).
  always_comb begin
    exp_val      = (prev_q == WIDTH'(MAX)) ? '0 : prev_q + WIDTH'(1);
    in_range     = (bus.cnt_in <= WIDTH'(MAX));
    good         = prev_valid_q && in_range && (bus.cnt_in == exp_val);
    is_wrap      = (prev_q == WIDTH'(MAX)) && (bus.cnt_in == '0);
    good_run_inc = good_run_q + GR_W'(1);
  end

  // Next-state and next-output logic. locked is derived from the next state
  // so it rises the cycle after the locking sample and drops together with
  // err_pulse on a mismatch.
  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    good_run_d   = good_run_q;
    err_pulse_d  = 1'b0;
    wrap_pulse_d = 1'b0;
    err_flag     = 1'b0;

    if (!bus.en) begin
      state_d      = IDLE;
      prev_valid_d = 1'b0;
    end else begin
      case (state_q)
        SYNC: begin
          prev_d = bus.cnt_in;
          if (good) begin
            good_run_d = good_run_inc;
            if (good_run_inc >= GR_W'(SYNC_LEN)) begin
              state_d = LOCKED;
            end
          end else begin
            good_run_d = '0;
          end
        end
        LOCKED: begin
          prev_d = bus.cnt_in;
          if (good) begin
            wrap_pulse_d = is_wrap;
          end else begin
            err_flag    = 1'b1;
            err_pulse_d = 1'b1;
            good_run_d  = '0;
            state_d     = SYNC;
          end
        end
        default: begin
          prev_d       = bus.cnt_in;
          prev_valid_d = 1'b1;
          good_run_d   = '0;
          state_d      = SYNC;
        end
      endcase
    end

    locked_d = (state_d == LOCKED);

    // A new error beats a simultaneous clear
    if (err_flag) begin
      err_sticky_d = 1'b1;
      last_bad_d   = bus.cnt_in;
    end else if (bus.clr) begin
      err_sticky_d = 1'b0;
      last_bad_d   = '0;
    end else begin
      err_sticky_d = err_sticky_q;
      last_bad_d   = last_bad_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      good_run_q   <= '0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      wrap_pulse_q <= 1'b0;
      err_sticky_q <= 1'b0;
      last_bad_q   <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      good_run_q   <= good_run_d;
      locked_q     <= locked_d;
      err_pulse_q  <= err_pulse_d;
      wrap_pulse_q <= wrap_pulse_d;
      err_sticky_q <= err_sticky_d;
      last_bad_q   <= last_bad_d;
    end
  end

  // Wrap counter advances on the same edge that registers wrap_pulse
  sat_counter #(
    .WRAP_W (WRAP_W)
  ) u_wrap_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (wrap_pulse_d),
    .clr   (bus.clr),
    .count (bus.wrap_cnt)
  );

  assign bus.locked     = locked_q;
  assign bus.err_pulse  = err_pulse_q;
  assign bus.wrap_pulse = wrap_pulse_q;
  assign bus.err_sticky = err_sticky_q;
  assign bus.last_bad   = last_bad_q;

endmodule
